// File: rtl/issue_stage_if.sv
// rtl/issue_stage_if.sv - lane-group bus (valid/type/payload per lane, stop back-pressure)
interface issue_stage_if #(
  parameter int W         = 2,
  parameter int PAYLOAD_W = 128
);
  logic [W-1:0]           valid;
  logic [3*W-1:0]         st_type;
  logic [PAYLOAD_W*W-1:0] payload;
  logic                   stop;

  // Downstream of the issue stage has no back-pressure, so the producer side carries no stop.
  modport master (output valid, st_type, payload);
  modport slave  (input valid, st_type, payload, output stop);
endinterface

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - W-lane in-order credit-based issue stage with partial issue
// Optional statistics counters enabled by defining ISSUE_STATS_EN.
module issue_stage #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PAYLOAD_W   = 128,
  parameter int ALU_DEPTH   = 8,
  parameter int BR_DEPTH    = 4,
  parameter int LS_DEPTH    = 8,
  parameter int MD_DEPTH    = 4,
  parameter int ROB_DEPTH   = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  issue_stage_if.slave                       in_bus,
  issue_stage_if.master                      out_bus,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   ret_alu,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   ret_br,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   ret_ls,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   ret_md,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   ret_rob,
  output logic [31:0]                        stat_stall,
  output logic [31:0]                        stat_issued
);
  localparam int W  = ISSUE_WIDTH;
  localparam int CW = 16;

  typedef logic [CW-1:0] cred_t;

  function automatic cred_t depth_of(input int k);
    case (k)
      0:       return cred_t'(ALU_DEPTH);
      1:       return cred_t'(BR_DEPTH);
      2:       return cred_t'(LS_DEPTH);
      3:       return cred_t'(ROB_DEPTH);
      default: return cred_t'(MD_DEPTH);
    endcase
  endfunction

  // Credit slots follow the station-type encoding; slot 3 (RB) holds the ROB credit.
  cred_t                  credit    [5];
  cred_t                  used      [5];
  cred_t                  ret       [5];
  cred_t                  cred_next [5];
  logic  [4:0]            over;
  logic  [W-1:0]          hold_valid;
  logic  [3*W-1:0]        hold_st;
  logic  [PAYLOAD_W*W-1:0] hold_payload;
  logic  [W-1:0]          issuable;
  logic                   stop;

  assign in_bus.stop = stop;

  always_comb begin
    logic [2:0] st;
    logic [2:0] sidx;
    logic       has_st;
    logic       ok;
    for (int k = 0; k < 5; k++) used[k] = '0;
    issuable = '0;
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      st     = hold_st[3*i +: 3];
      has_st = (st == 3'd0) || (st == 3'd1) || (st == 3'd2) || (st == 3'd4);
      sidx   = has_st ? st : 3'd3;
      ok     = ok && (!hold_valid[i] ||
                      ((credit[3] > used[3]) && (credit[sidx] > used[sidx])));
      issuable[i] = ok;
      if (ok && hold_valid[i]) begin
        used[3] = used[3] + cred_t'(1);
        if (has_st) used[sidx] = used[sidx] + cred_t'(1);
      end
    end
  end

  assign stop = |(hold_valid & ~issuable);

  always_comb begin
    logic [CW:0] sum;
    ret[0] = cred_t'(ret_alu);
    ret[1] = cred_t'(ret_br);
    ret[2] = cred_t'(ret_ls);
    ret[3] = cred_t'(ret_rob);
    ret[4] = cred_t'(ret_md);
    over   = '0;
    for (int k = 0; k < 5; k++) begin
      sum          = {1'b0, credit[k]} - {1'b0, used[k]} + {1'b0, ret[k]};
      over[k]      = sum > {1'b0, depth_of(k)};
      cred_next[k] = over[k] ? depth_of(k) : sum[CW-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid      <= '0;
      hold_st         <= '0;
      hold_payload    <= '0;
      out_bus.valid   <= '0;
      out_bus.st_type <= '0;
      out_bus.payload <= '0;
      for (int k = 0; k < 5; k++) credit[k] <= depth_of(k);
    end else if (flush) begin
      hold_valid    <= '0;
      out_bus.valid <= '0;
      for (int k = 0; k < 5; k++) credit[k] <= depth_of(k);
    end else begin
      out_bus.valid   <= hold_valid & issuable;
      out_bus.st_type <= hold_st;
      out_bus.payload <= hold_payload;
      for (int k = 0; k < 5; k++) credit[k] <= cred_next[k];
      if (!stop) begin
        hold_valid   <= in_bus.valid;
        hold_st      <= in_bus.st_type;
        hold_payload <= in_bus.payload;
      end else begin
        hold_valid <= hold_valid & ~issuable;
      end
    end
  end

  // Returning more entries than a station holds is an upstream protocol error.
  credit_overflow: assert property (@(posedge clock) disable iff (reset)
    !flush |-> (over == 5'd0));

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_stall  <= '0;
      stat_issued <= '0;
    end else if (flush) begin
      stat_stall  <= '0;
      stat_issued <= '0;
    end else begin
      stat_stall  <= stat_stall + {31'd0, stop};
      stat_issued <= stat_issued + 32'($countones(out_bus.valid));
    end
  end
`else
  assign stat_stall  = '0;
  assign stat_issued = '0;
`endif

endmodule
